// File: rtl/mux8_rr_sched_pkg.sv
// mux_sched_pkg: shared state encoding and widths for the 8-way round-robin mux scheduler
package mux_sched_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int NREQ = 8;
    localparam int SELW = 3;
endpackage

// File: rtl/mux8_rr_sched_if.sv
// mux8_rr_sched_if: requester/consumer bundle around the scheduler
// master: drives req, din, ready; observes sel, gnt, valid, y, busy
// slave:  the scheduler side of the same signals
interface mux8_rr_sched_if;
    import mux_sched_pkg::*;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] din;
    logic            ready;
    logic [SELW-1:0] sel;
    logic [NREQ-1:0] gnt;
    logic            valid;
    logic            y;
    logic            busy;
    modport master(output req, din, ready, input sel, gnt, valid, y, busy);
    modport slave(input req, din, ready, output sel, gnt, valid, y, busy);
endinterface

// File: rtl/mux8.sv
// mux8: 8:1 single-bit mux built as a three-level 2:1 tree
// din: data inputs, sel: select, y: din[sel]
module mux8
    import mux_sched_pkg::*;
(
    input  logic [NREQ-1:0] din,
    input  logic [SELW-1:0] sel,
    output logic            y
);
    logic [3:0] l1;
    logic [1:0] l2;
    for (genvar g = 0; g < 4; g++) begin : g_l1
        assign l1[g] = sel[0] ? din[2*g+1] : din[2*g];
    end
    for (genvar g = 0; g < 2; g++) begin : g_l2
        assign l2[g] = sel[1] ? l1[2*g+1] : l1[2*g];
    end
    assign y = sel[2] ? l2[1] : l2[0];
endmodule

// File: rtl/rr_search8.sv
// rr_search8: circular priority search over 8 requests starting at index start
// req: request vector, start: first index to look at
// idx: first set request in order start, start+1, ... (wraps), any: some request set
module rr_search8
    import mux_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] idx,
    output logic            any
);
    // Scan farthest-first so the closest hit to start overwrites the rest
    always_comb begin
        idx = start;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[start + SELW'(i)]) idx = start + SELW'(i);
        end
    end
    assign any = |req;
endmodule

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin owner of one 8:1 mux lane, granting bursts of up to BURST beats
// clk, rst: clock and synchronous active-high reset
// bus (slave): req/din/ready in; registered sel/gnt/busy out; valid and y combinational
module mux8_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int BURST = 4
)(
    input  logic                 clk,
    input  logic                 rst,
    mux8_rr_sched_if.slave       bus
);
    localparam int CW = BURST > 1 ? $clog2(BURST) : 1;

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SELW-1:0] start;
    logic [SELW-1:0] idx;
    logic            any;
    logic            mux_y;
    logic            xfer;
    logic            rel;

    // One search serves both idle arbitration (from ptr) and release hand-over (from sel+1)
    assign start = state_q == IDLE ? ptr_q : sel_q + SELW'(1);

    rr_search8 u_search (.req(bus.req), .start(start), .idx(idx), .any(any));
    mux8       u_mux    (.din(bus.din), .sel(sel_q), .y(mux_y));

    assign bus.valid = state_q == BUSY && bus.req[sel_q];
    assign bus.y     = bus.valid & mux_y;
    assign bus.sel   = sel_q;
    assign bus.gnt   = gnt_q;
    assign bus.busy  = state_q == BUSY;
    assign xfer      = bus.valid & bus.ready;
    assign rel       = state_q == BUSY && ((xfer && cnt_q == CW'(BURST - 1)) || !bus.req[sel_q]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        if (rel) ptr_d = sel_q + SELW'(1);
        if ((state_q == IDLE || rel) && any) begin
            state_d = BUSY;
            sel_d   = idx;
            gnt_d   = NREQ'(1) << idx;
            cnt_d   = '0;
        end else if (rel) begin
            state_d = IDLE;
            gnt_d   = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares one 8:1 single-bit mux lane between eight requesters. It arbitrates the `req` lines, drives the mux select, and grants each owner a burst of up to `BURST` beats. Beats are transferred to a downstream consumer over a valid/ready handshake. It sits directly in front of the 8:1 mux datapath and is the only block that drives its select.

## Interface
- `BURST`, default 4: maximum beats per grant; legal range 1..256.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `req`  input  8  request per requester; bit k set means requester k has data on `din[k]`.
- `din`  input  8  data bit per requester.
- `ready`  input  1  downstream accepts the current beat.
- `sel`  output  3  registered mux select, equal to the owner index.
- `gnt`  output  8  registered one-hot grant, zero when idle.
- `valid`  output  1  beat present; `busy & req[sel]`.
- `y`  output  1  `din[sel]` when `valid`, otherwise 0.
- `busy`  output  1  registered; high in state BUSY.

## Operation
- State: `{IDLE, BUSY}`, plus:
  - `ptr` (3b): next search start.
  - `cnt`: `$clog2(BURST)` bits, minimum 1.
- Transfer: `valid & ready` at a rising edge.
- Search(start): lowest k in the circular order `start, start+1, … start+7` (mod 8) with `req[k]=1`. The result is undefined if `req=0`.
- IDLE:
  - `gnt=0`, `valid=0`.
  - If `req!=0`: owner = search(`ptr`); go to BUSY with `sel=owner`, `gnt=1<<owner`, `cnt=0`.
- BUSY, release condition: (transfer and `cnt==BURST-1`) or `req[sel]==0`.
- BUSY, no release:
  - On transfer, `cnt<=cnt+1`.
  - Otherwise hold all state. `ready` low stalls `cnt`, `sel` and `gnt`.
- BUSY, on release:
  - `ptr<=sel+1` (wraps 7→0).
  - If `req!=0`: switch directly to owner = search(`sel+1`) with `cnt=0`; there is no idle bubble.
  - The current owner is re-granted only if it is the sole requester and still requesting.
  - If `req==0`: go to IDLE with `gnt=0`; `sel` holds its last value.
- Owner drop: if `req[sel]` falls mid-burst, `valid` goes low the same cycle and release happens at the next edge. `din` is not sampled that cycle.
- Non-owner requests have no effect until re-arbitration.
- `ready` without `valid` is ignored.
- `y` is purely combinational from registered `sel` and live `din`/`req`.

## Timing
- Reset values: `sel=0`, `gnt=0`, `busy=0`, `valid=0`, `y=0`, `ptr=0`, `cnt=0`, state IDLE.
- `rst` wins over every other event.
- Reset mid-burst abandons the burst; outputs take reset values after that edge.
- Latency from request in IDLE to grant: 1 cycle.
- Hand-over on release with other requesters pending: 0 idle cycles; the new `gnt` appears the edge after the last beat.
- With `ready` held high and requests held, a burst lasts exactly `BURST` cycles.
- `BURST=1`: pure per-beat round-robin.
- A single continuous requester gets back-to-back bursts with no gap.

## Structure
- Shared package (`mux_sched_pkg`):
  - state enum `{IDLE, BUSY}`;
  - constant `NREQ=8`;
  - select width `SELW=3`.
- Sub-module `rr_search8`: combinational circular priority search taking `req[7:0]` and `start[2:0]`, returning `idx[2:0]` and `any`. It is used for both the IDLE search and the release search.
- The data path instantiates the team's existing 8:1 mux (three-level 2:1 tree) driven by `sel`; `y` is gated by `valid`.

## Test plan
- Reset: hold `rst` for 2 cycles with random `req`/`din` → `sel=0`, `gnt=0`, `busy=0`, `valid=0`, `y=0` after the first edge.
- Single requester: `req=8'h20`, `ready=1`, `BURST=4` → `gnt=8'h20` one cycle later, `sel=5`, and `valid` continuously high across back-to-back bursts with no gap.
- Full load: `req=8'hFF`, `ready=1`, `BURST=4` → owners 0,1,2,…,7,0, each for exactly 4 cycles; `gnt` is always one-hot.
- Stall: owner 2 with `ready` low for 3 cycles mid-burst → `cnt`, `sel` and `gnt` frozen; the burst completes after 4 total transfers.
- Owner drop: owner 1 drops `req` after 2 beats with `req[6]` pending → `valid=0` that cycle, then `gnt=8'h40` on the next edge.
- Reset mid-burst: assert `rst` during the beat-2 transfer → all outputs at reset values after that edge; the next grant search starts from index 0.
